mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port (I, read-only) and data-memory port (D, load/store).
- Sits between the IF/MEM stages and the memory model. Its ready/valid outputs drive the pipeline stall logic.
- Arbitrates D over I, with an anti-starvation counter. Sequences each access with a latency counter.

Parameters:
- LATENCY, 4: memory access cycles per transaction. Legal range is 1 to 15.
- STARVE_LIMIT, 3: maximum consecutive D grants while i_req is pending. After that, I wins the next arbitration. Legal range is 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until accepted.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_valid  out  1  fetch data valid; one-cycle pulse.
- i_rdata  out  32  fetch data; meaningful only when i_valid=1.
- d_req  in  1  data request; held until accepted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  data request accepted this cycle.
- d_valid  out  1  load data / store completion; one-cycle pulse.
- d_rdata  out  32  load data; 0 for stores.
- mem_en  out  1  memory access in progress.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the last BUSY cycle.

Behaviour:
- States are IDLE, BUSY, DONE. Internal registers:
  - owner (I/D)
  - lat_cnt, width clog2(LATENCY+1)
  - starve_cnt, width 4
  - latched addr/we/wdata
  - rdata register
- Reset (any cycle, including mid-transaction):
  - state goes to IDLE; lat_cnt=0; starve_cnt=0; owner=I.
  - The in-flight transaction is dropped. No valid pulse follows and no write is committed.
  - All outputs are 0.
- IDLE:
  - i_ready/d_ready are combinational and asserted only in IDLE.
  - If d_req and not (i_req and starve_cnt==STARVE_LIMIT): d_ready=1, grant D.
  - Else if i_req: i_ready=1, grant I.
  - At most one ready is high per cycle. Never ready without the matching req.
  - On a grant: latch addr/we/wdata (we forced 0 for I), set owner, set lat_cnt=LATENCY, go to BUSY.
  - starve_cnt update on a grant:
    - D granted while i_req=1: starve_cnt increments, saturating at 15.
    - I granted: starve_cnt clears.
    - D granted while i_req=0: starve_cnt clears.
- BUSY:
  - mem_en=1; mem_addr/mem_wdata come from the latched values.
  - lat_cnt decrements each cycle.
  - The final BUSY cycle is when lat_cnt==1:
    - mem_we = latched we, high in exactly this one cycle.
    - mem_rdata is captured into the rdata register (0 if a store).
    - Next state is DONE.
- DONE (one cycle):
  - Pulse i_valid or d_valid per owner. Matching rdata output = rdata register.
  - Other port's valid/rdata = 0. mem_en=0.
  - Next state is IDLE. No acceptance in DONE.
- Latency: request accepted in cycle T gives:
  - mem_en high in cycles T+1..T+LATENCY;
  - valid in cycle T+LATENCY+1;
  - earliest next accept in cycle T+LATENCY+2.
- Outside their stated cycles, mem_we/mem_en/valids are 0. mem_addr/mem_wdata hold their last latched values; they are don't-care when mem_en=0.
- Requester inputs are ignored after acceptance. Changing d_addr during BUSY has no effect.
- Address is passed through unmodified; no alignment check.
- LATENCY=1 is legal: one BUSY cycle, which is also the final cycle.

Test Plan:
- Single load: with LATENCY=4, d_req=1, d_we=0, d_addr=0x100 in cycle 0 → d_ready=1 in cycle 0. mem_en=1 and mem_addr=0x100 in cycles 1–4. mem_rdata=0xDEADBEEF in cycle 4 → d_valid=1, d_rdata=0xDEADBEEF in cycle 5; i_valid=0.
- Store: d_we=1, d_addr=0x20, d_wdata=0x12345678 → mem_we=1 only in cycle 4 with matching addr/wdata. d_valid=1, d_rdata=0 in cycle 5.
- Contention: i_req and d_req both high in cycle 0 → d_ready=1 and i_ready=0 in cycle 0. i_ready=1 in cycle 6 (the first IDLE after DONE).
- Starvation: i_req held high and d_req held high continuously, STARVE_LIMIT=3 → three D grants in a row, then i_ready=1 on the fourth grant. The following grant is D again.
- Reset mid-op: assert reset in cycle 2 of a store → mem_we never pulses; no d_valid. All outputs are 0 in the cycle after reset. With reset deasserted and i_req=1, i_ready=1 in the next IDLE cycle.
- LATENCY=1 back-to-back fetches: i_req held high → i_ready in cycles 0, 3, 6. i_valid in cycles 2, 5, 8. mem_en in cycles 1, 4, 7.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch (I) and data (D) ports.
// D has priority; an anti-starvation counter hands I the next grant after STARVE_LIMIT D wins.
module mem_port_arbiter #(
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LatW      = $clog2(LATENCY + 1);
  localparam logic [LatW-1:0] LatInit = LatW'(LATENCY);
  localparam logic [3:0] StarveMax  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_owner_d;
  logic [LatW-1:0]   r_lat_cnt;
  logic [3:0]        r_starve_cnt;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic              r_we;
  logic              w_grant_d, w_grant_i, w_last, w_live;

  always_comb begin
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_state_next = r_state;
    w_last       = (r_state == StBusy) && (r_lat_cnt == LatW'(1));
    unique case (r_state)
      StIdle: begin
        if (d_req && !(i_req && (r_starve_cnt == StarveMax))) begin
          w_grant_d = 1'b1;
        end else if (i_req) begin
          w_grant_i = 1'b1;
        end
        if (w_grant_d || w_grant_i) w_state_next = StBusy;
      end
      StBusy: if (w_last) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_owner_d    <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_d || w_grant_i) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ? d_addr : i_addr;
        r_wdata   <= w_grant_d ? d_wdata : 32'h0;
        r_we      <= w_grant_d & d_we;
        r_lat_cnt <= LatInit;
        // Only D wins that leave a fetch waiting count toward starvation
        if (w_grant_d && i_req) begin
          r_starve_cnt <= (r_starve_cnt == 4'hF) ? 4'hF : r_starve_cnt + 4'd1;
        end else begin
          r_starve_cnt <= '0;
        end
      end
      if (r_state == StBusy) r_lat_cnt <= r_lat_cnt - LatW'(1);
      if (w_last) r_rdata <= r_we ? 32'h0 : mem_rdata;
    end
  end

  // Outputs are forced low while reset is held so a dying transaction cannot commit a write
  assign w_live    = !reset;
  assign i_ready   = w_live & w_grant_i;
  assign d_ready   = w_live & w_grant_d;
  assign mem_en    = w_live & (r_state == StBusy);
  assign mem_we    = w_live & w_last & r_we;
  assign mem_addr  = w_live ? r_addr : 32'h0;
  assign mem_wdata = w_live ? r_wdata : 32'h0;
  assign i_valid   = w_live & (r_state == StDone) & !r_owner_d;
  assign d_valid   = w_live & (r_state == StDone) & r_owner_d;
  assign i_rdata   = i_valid ? r_rdata : 32'h0;
  assign d_rdata   = d_valid ? r_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration vector table, random traffic against a transaction-level
// model, and directed multi-cycle sequences (load, store, contention, starvation, reset, LATENCY=1).
module tb_mem_port_arbiter;
  localparam int L  = 4;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_valid, d_ready, d_valid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        u1_i_req, u1_d_req, u1_d_we;
  logic [31:0] u1_i_addr, u1_d_addr, u1_d_wdata;
  logic        u1_i_ready, u1_i_valid, u1_d_ready, u1_d_valid, u1_mem_en, u1_mem_we;
  logic [31:0] u1_i_rdata, u1_d_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(u1_i_req), .i_addr(u1_i_addr), .i_ready(u1_i_ready), .i_valid(u1_i_valid),
    .i_rdata(u1_i_rdata),
    .d_req(u1_d_req), .d_we(u1_d_we), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
    .d_ready(u1_d_ready), .d_valid(u1_d_valid), .d_rdata(u1_d_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata)
  );

  // Environment memory: 16 words indexed by addr[5:2], read combinationally
  logic [31:0] env_mem [16];
  logic        env_init;
  logic [31:0] ref_mem [16];

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
    end else if (mem_we) begin
      env_mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata    = env_mem[mem_addr[5:2]];
  assign u1_mem_rdata = u1_mem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " i_ready"}, 32'(i_ready), 0);
    chk({tag, " d_ready"}, 32'(d_ready), 0);
    chk({tag, " i_valid"}, 32'(i_valid), 0);
    chk({tag, " d_valid"}, 32'(d_valid), 0);
    chk({tag, " i_rdata"}, i_rdata, 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
    chk({tag, " mem_en"}, 32'(mem_en), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a      = $urandom;
    a[5:2] = 4'($urandom_range(1, 15));  // word 0 is kept for the directed load
    return a;
  endfunction

  typedef struct {
    logic ir, dr, exp_ir_rdy, exp_dr_rdy;
  } vec_t;
  vec_t vecs[4];

  // Transaction-level reference: cycles since acceptance (0 = no transaction)
  int          m_k, m_starve;
  logic        m_owner_d, m_we;
  logic [31:0] m_addr, m_wdata, m_rd;

  initial begin
    logic ip, dp, eg_d, eg_i;
    vecs[0] = '{ir: 0, dr: 0, exp_ir_rdy: 0, exp_dr_rdy: 0};
    vecs[1] = '{ir: 1, dr: 0, exp_ir_rdy: 1, exp_dr_rdy: 0};
    vecs[2] = '{ir: 0, dr: 1, exp_ir_rdy: 0, exp_dr_rdy: 1};
    vecs[3] = '{ir: 1, dr: 1, exp_ir_rdy: 0, exp_dr_rdy: 1};

    reset = 1'b1; env_init = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    u1_i_req = 0; u1_d_req = 0; u1_d_we = 0; u1_i_addr = 32'h1000; u1_d_addr = 0; u1_d_wdata = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) next_cycle();
    reset = 1'b0; env_init = 1'b0;
    settle();
    chk_all_zero("post_reset");

    // Arbitration table, evaluated combinationally within one IDLE cycle
    for (int v = 0; v < 4; v++) begin
      i_req = vecs[v].ir; d_req = vecs[v].dr;
      #1;
      chk($sformatf("vec%0d i_ready", v), 32'(i_ready), 32'(vecs[v].exp_ir_rdy));
      chk($sformatf("vec%0d d_ready", v), 32'(d_ready), 32'(vecs[v].exp_dr_rdy));
    end
    i_req = 0; d_req = 0;
    next_cycle();

    // Random traffic against the reference model
    m_k = 0; m_starve = 0; m_owner_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
    ip = 0; dp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!ip) begin ip = ($urandom_range(0, 3) != 0); i_addr = rand_addr(); end
      if (!dp) begin
        dp = ($urandom_range(0, 3) != 0); d_addr = rand_addr();
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      i_req = ip; d_req = dp;
      settle();
      eg_d = (m_k == 0) && d_req && !(i_req && m_starve == SL);
      eg_i = (m_k == 0) && !eg_d && i_req;
      chk("rnd i_ready", 32'(i_ready), 32'(eg_i));
      chk("rnd d_ready", 32'(d_ready), 32'(eg_d));
      chk("rnd mem_en", 32'(mem_en), 32'(m_k >= 1 && m_k <= L));
      chk("rnd mem_we", 32'(mem_we), 32'(m_k == L && m_we));
      chk("rnd i_valid", 32'(i_valid), 32'(m_k == L + 1 && !m_owner_d));
      chk("rnd d_valid", 32'(d_valid), 32'(m_k == L + 1 && m_owner_d));
      if (m_k >= 1 && m_k <= L) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        if (m_we) chk("rnd mem_wdata", mem_wdata, m_wdata);
      end
      if (m_k == L + 1) begin
        chk("rnd rdata", m_owner_d ? d_rdata : i_rdata, m_rd);
        chk("rnd other rdata", m_owner_d ? i_rdata : d_rdata, 0);
      end
      if (eg_d || eg_i) begin
        m_k = 1; m_owner_d = eg_d;
        m_addr = eg_d ? d_addr : i_addr; m_we = eg_d && d_we; m_wdata = d_wdata;
        m_starve = (eg_d && i_req) ? ((m_starve == 15) ? 15 : m_starve + 1) : 0;
        if (eg_d) dp = 0; else ip = 0;
      end else if (m_k > 0) begin
        if (m_k == L) begin
          m_rd = m_we ? 32'h0 : ref_mem[m_addr[5:2]];
          if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
        end
        m_k = (m_k == L + 1) ? 0 : m_k + 1;
      end
      next_cycle();
    end
    i_req = 0; d_req = 0; d_we = 0;
    reset = 1'b1; env_init = 1'b1;
    next_cycle();
    reset = 1'b0; env_init = 1'b0;

    // Single load from 0x100 (word 0 holds 0xDEADBEEF)
    d_req = 1; d_we = 0; d_addr = 32'h100;
    settle();
    chk("load d_ready", 32'(d_ready), 1);
    chk("load i_ready", 32'(i_ready), 0);
    next_cycle();
    d_req = 0; d_addr = 32'hFFFF_FFF0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("load c%0d mem_en", c), 32'(mem_en), 1);
      chk($sformatf("load c%0d mem_addr", c), mem_addr, 32'h100);
      next_cycle();
    end
    settle();
    chk("load d_valid", 32'(d_valid), 1);
    chk("load d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("load i_valid", 32'(i_valid), 0);
    chk("load mem_en", 32'(mem_en), 0);
    next_cycle();

    // Store 0x12345678 to 0x20
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    settle();
    chk("store d_ready", 32'(d_ready), 1);
    next_cycle();
    d_req = 0; d_we = 0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("store c%0d mem_we", c), 32'(mem_we), 32'(c == 4));
      chk($sformatf("store c%0d mem_addr", c), mem_addr, 32'h20);
      chk($sformatf("store c%0d mem_wdata", c), mem_wdata, 32'h1234_5678);
      next_cycle();
    end
    settle();
    chk("store d_valid", 32'(d_valid), 1);
    chk("store d_rdata", d_rdata, 0);
    next_cycle();

    // Contention: D first, I accepted in the first IDLE after DONE
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h44; i_addr = 32'h80;
    settle();
    chk("cont c0 d_ready", 32'(d_ready), 1);
    chk("cont c0 i_ready", 32'(i_ready), 0);
    next_cycle();
    d_req = 0;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk($sformatf("cont c%0d i_ready", c), 32'(i_ready), 32'(c == 6));
      next_cycle();
    end
    i_req = 0;
    repeat (5) next_cycle();

    // Starvation: grants D, D, D, I, D with both requests held
    i_req = 1; d_req = 1;
    for (int g = 0; g < 5; g++) begin
      settle();
      chk($sformatf("starve g%0d d_ready", g), 32'(d_ready), 32'(g != 3));
      chk($sformatf("starve g%0d i_ready", g), 32'(i_ready), 32'(g == 3));
      next_cycle();
      if (g == 4) begin i_req = 0; d_req = 0; end
      repeat (5) next_cycle();
    end

    // Reset in cycle 2 of a store: no write strobe, no valid
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
    settle();
    chk("rst d_ready", 32'(d_ready), 1);
    next_cycle();
    d_req = 0; d_we = 0;
    settle();
    chk("rst c1 mem_en", 32'(mem_en), 1);
    next_cycle();
    reset = 1'b1;
    settle();
    chk("rst c2 mem_we", 32'(mem_we), 0);
    next_cycle();
    reset = 1'b0;
    settle();
    chk_all_zero("rst c3");
    for (int c = 4; c <= 7; c++) begin
      next_cycle();
      settle();
      chk($sformatf("rst c%0d activity", c), {29'h0, mem_en, mem_we, d_valid}, 0);
    end
    i_req = 1; i_addr = 32'h3C;
    settle();
    chk("rst i_ready", 32'(i_ready), 1);
    next_cycle();
    i_req = 0;
    repeat (5) next_cycle();

    // LATENCY=1 back-to-back fetches
    u1_i_req = 1;
    for (int c = 0; c <= 8; c++) begin
      settle();
      chk($sformatf("lat1 c%0d i_ready", c), 32'(u1_i_ready), 32'(c % 3 == 0));
      chk($sformatf("lat1 c%0d mem_en", c), 32'(u1_mem_en), 32'(c % 3 == 1));
      chk($sformatf("lat1 c%0d i_valid", c), 32'(u1_i_valid), 32'(c % 3 == 2));
      if (c % 3 == 2) chk($sformatf("lat1 c%0d i_rdata", c), u1_i_rdata, 32'hA5A5_1000);
      next_cycle();
    end
    u1_i_req = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
